// File: rtl/serpent_pkg.sv
// Shared Serpent constants, FSM state type and the S-box / linear-transform helpers.
// The inverse helpers are only reached when SERPENT_DEC_EN is defined.
package serpent_pkg;

  localparam int SERPENT_ROUNDS   = 32;
  localparam int SERPENT_NSUBKEYS = 33;
  localparam int BLOCK_W          = 128;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Row b holds S_b; entry n sits at bits [4n+:4].
  localparam logic [63:0] SBOX_TAB [8] = '{
    64'hC90724DEB56A1F83, 64'h43D68EB1A50972CF,
    64'h25B04E1DFAC39768, 64'hE57A421D369C8BF0,
    64'hD7E9A4526B0C38F1, 64'h176D8E30C9A4B25F,
    64'h0A3DF19EB6485C27, 64'h6539AC47B28E0FD1
  };

  function automatic logic [2:0] sbox_idx(logic [5:0] round);
    return round[2:0];
  endfunction

  function automatic logic [3:0] sbox_fwd(logic [2:0] b, logic [3:0] n);
    logic [63:0] row;
    row = SBOX_TAB[b];
    return row[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(logic [2:0] b, logic [3:0] n);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      if (sbox_fwd(b, 4'(k)) == n) r = 4'(k);
    return r;
  endfunction

  // Bitslice layer: nibble i is {w3[i],w2[i],w1[i],w0[i]} with w0 = bits [31:0].
  function automatic logic [127:0] sbox_layer(logic [127:0] x, logic [2:0] b, logic inv);
    logic [127:0] y;
    logic [3:0]   nib, v;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      nib = {x[96+i], x[64+i], x[32+i], x[i]};
      v   = inv ? sbox_inv(b, nib) : sbox_fwd(b, nib);
      y[i]    = v[0];
      y[32+i] = v[1];
      y[64+i] = v[2];
      y[96+i] = v[3];
    end
    return y;
  endfunction

  function automatic logic [31:0] rotl(logic [31:0] x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] lt_fwd(logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = x;
    x0 = rotl(x0, 13);
    x2 = rotl(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rotl(x1, 1);
    x3 = rotl(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rotl(x0, 5);
    x2 = rotl(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] lt_inv(logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = x;
    x2 = rotl(x2, 10);
    x0 = rotl(x0, 27);
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = x0 ^ x1 ^ x3;
    x3 = rotl(x3, 25);
    x1 = rotl(x1, 31);
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = x1 ^ x0 ^ x2;
    x2 = rotl(x2, 29);
    x0 = rotl(x0, 19);
    return {x3, x2, x1, x0};
  endfunction

endpackage

// File: rtl/serpent_round_unit.sv
// One combinational Serpent round; last_i swaps the LT for the K32 whitening.
// Decrypt path exists only when SERPENT_DEC_EN is defined.
module serpent_round_unit
  import serpent_pkg::*;
(
  input  logic [BLOCK_W-1:0] x_i,
  input  logic [BLOCK_W-1:0] key_i,
  input  logic [BLOCK_W-1:0] key32_i,
  input  logic [2:0]         sbox_i,
  input  logic               dec_i,
  input  logic               last_i,
  output logic [BLOCK_W-1:0] y_o
);

  logic [BLOCK_W-1:0] enc_s, enc_y;

  assign enc_s = sbox_layer(x_i ^ key_i, sbox_i, 1'b0);
  assign enc_y = last_i ? (enc_s ^ key32_i) : lt_fwd(enc_s);

`ifdef SERPENT_DEC_EN
  logic [BLOCK_W-1:0] dec_t, dec_y;
  assign dec_t = last_i ? (x_i ^ key32_i) : lt_inv(x_i);
  assign dec_y = sbox_layer(dec_t, sbox_i, 1'b1) ^ key_i;
  assign y_o   = dec_i ? dec_y : enc_y;
`else
  logic unused_dec;
  assign unused_dec = dec_i;
  assign y_o        = enc_y;
`endif

endmodule

// File: rtl/serpent_round_engine.sv
// Iterative Serpent core, UNROLL rounds per clock, valid/ready on both sides.
// SERPENT_DEC_EN enables decryption; otherwise i_decrypt is ignored.
module serpent_round_engine
  import serpent_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int DATA_W = BLOCK_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_decrypt,
  output logic [5:0]               o_subkey_idx,
  input  logic [UNROLL*BLOCK_W-1:0] i_subkeys,
  input  logic [BLOCK_W-1:0]       i_subkey32,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_W-1:0]        o_data
);

  state_e             state_q;
  logic [5:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, res_q;
  logic               dec_q, o_valid_q, o_ready_q;
  logic [BLOCK_W-1:0] chain [UNROLL+1];

  assign chain[0] = data_q;
  assign cnt_d    = cnt_q + 6'(UNROLL);

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    logic [5:0] rnd;
    assign rnd = dec_q ? (6'(SERPENT_ROUNDS - 1) - cnt_q - 6'(j)) : (cnt_q + 6'(j));
    serpent_round_unit u_round (
      .x_i     (chain[j]),
      .key_i   (i_subkeys[j*BLOCK_W +: BLOCK_W]),
      .key32_i (i_subkey32),
      .sbox_i  (sbox_idx(rnd)),
      .dec_i   (dec_q),
      .last_i  (rnd == 6'(SERPENT_ROUNDS - 1)),
      .y_o     (chain[j+1])
    );
  end

`ifndef SERPENT_DEC_EN
  logic unused_decrypt;
  assign unused_decrypt = i_decrypt;
  assign dec_q          = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      res_q     <= '0;
      o_valid_q <= 1'b0;
      o_ready_q <= 1'b1;
`ifdef SERPENT_DEC_EN
      dec_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          data_q    <= i_data;
          cnt_q     <= '0;
          o_ready_q <= 1'b0;
          state_q   <= RUN;
`ifdef SERPENT_DEC_EN
          dec_q     <= i_decrypt;
`endif
        end
        RUN: begin
          data_q <= chain[UNROLL];
          if (cnt_d == 6'(SERPENT_ROUNDS)) begin
            res_q     <= chain[UNROLL];
            cnt_q     <= '0;
            o_valid_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: if (i_ready) begin
          o_valid_q <= 1'b0;
          o_ready_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Decrypt walks the key store downward from K31.
  assign o_subkey_idx = (state_q != RUN) ? 6'd0 :
                        dec_q ? (6'(SERPENT_ROUNDS - 1) - cnt_q) : cnt_q;
  assign o_ready      = o_ready_q;
  assign o_valid      = o_valid_q;
  assign o_data       = res_q;

endmodule
